// File: rtl/conv_line_feeder.sv
// Line feeder for a 3-row conv core: buffers one D x H x W frame, then issues
// zero-padded row triplets per (row, channel) pass. Optional watchdog: CONV_FEEDER_TIMEOUT_EN.
module conv_line_feeder #(
    parameter int D                = 4,
    parameter int H                = 6,
    parameter int W                = 6,
    parameter int input_DATA_WIDTH = 8,
    parameter int TIMEOUT          = 1024
) (
    input  logic                                clk,
    input  logic                                rstn_i,
    input  logic signed [input_DATA_WIDTH-1:0]  pixel_i,
    input  logic                                pixel_valid_i,
    output logic                                pixel_ready_o,
    input  logic                                conv_done_i,
    output logic [input_DATA_WIDTH*(W+2)-1:0]   image0,
    output logic [input_DATA_WIDTH*(W+2)-1:0]   image1,
    output logic [input_DATA_WIDTH*(W+2)-1:0]   image2,
    output logic                                image_start,
    output logic                                busy_o,
    output logic                                frame_done_o
`ifdef CONV_FEEDER_TIMEOUT_EN
    ,
    output logic                                err_o
`endif
);

    localparam int DW   = input_DATA_WIDTH;
    localparam int RWB  = DW * (W + 2);
    localparam int N    = D * H * W;
    localparam int AW   = (N > 1) ? $clog2(N) : 1;
    localparam int HW   = (H > 1) ? $clog2(H) : 1;
    localparam int DPW  = (D > 1) ? $clog2(D) : 1;

    typedef enum logic [2:0] {IDLE, LOAD, ISSUE, WAIT, FIN} state_t;

    state_t         state;
    logic [DW-1:0]  frame [N];
    logic [AW-1:0]  pix_cnt;
    logic [HW-1:0]  row;
    logic [DPW-1:0] depth;
    logic [RWB-1:0] row_prev, row_cur, row_next;
    logic           xfer, last_pix, last_pass, done_ok;

    function automatic logic [AW-1:0] idx(int d, int r, int c);
        return AW'(d * H * W + r * W + c);
    endfunction

    // rstn_i is active-high; ready is masked so no pixel is taken while in reset
    assign pixel_ready_o = !rstn_i && (state == IDLE || state == LOAD);
    assign busy_o        = (state != IDLE);
    assign frame_done_o  = (state == FIN);

    assign xfer      = pixel_valid_i && pixel_ready_o;
    assign last_pix  = (pix_cnt == AW'(N - 1));
    assign last_pass = (row == HW'(H - 1)) && (depth == DPW'(D - 1));
    assign done_ok   = conv_done_i && !image_start;

    always_ff @(posedge clk) begin
        if (xfer) frame[pix_cnt] <= pixel_i;
    end

    always_comb begin
        row_prev = '0;
        row_cur  = '0;
        row_next = '0;
        for (int unsigned c = 0; c < W; c++) begin
            row_cur[DW*(c+1) +: DW] = frame[idx(int'(depth), int'(row), int'(c))];
            if (row != '0)
                row_prev[DW*(c+1) +: DW] = frame[idx(int'(depth), int'(row) - 1, int'(c))];
            if (row != HW'(H - 1))
                row_next[DW*(c+1) +: DW] = frame[idx(int'(depth), int'(row) + 1, int'(c))];
        end
    end

`ifdef CONV_FEEDER_TIMEOUT_EN
    localparam int TCW = $clog2(TIMEOUT + 1);
    logic [TCW-1:0] tcnt;
`endif

    always_ff @(posedge clk) begin
        if (rstn_i) begin
            state       <= IDLE;
            pix_cnt     <= '0;
            row         <= '0;
            depth       <= '0;
            image0      <= '0;
            image1      <= '0;
            image2      <= '0;
            image_start <= 1'b0;
`ifdef CONV_FEEDER_TIMEOUT_EN
            tcnt        <= '0;
            err_o       <= 1'b0;
`endif
        end else begin
            image_start <= 1'b0;
`ifdef CONV_FEEDER_TIMEOUT_EN
            err_o       <= 1'b0;
`endif
            case (state)
                IDLE, LOAD: begin
                    if (xfer) begin
                        if (last_pix) begin
                            state   <= ISSUE;
                            pix_cnt <= '0;
                        end else begin
                            state   <= LOAD;
                            pix_cnt <= pix_cnt + AW'(1);
                        end
                    end
                end
                ISSUE: begin
                    image0      <= row_prev;
                    image1      <= row_cur;
                    image2      <= row_next;
                    image_start <= 1'b1;
                    state       <= WAIT;
`ifdef CONV_FEEDER_TIMEOUT_EN
                    tcnt        <= '0;
`endif
                end
                WAIT: begin
                    if (done_ok) begin
                        if (last_pass) begin
                            state <= FIN;
                        end else begin
                            state <= ISSUE;
                            if (depth == DPW'(D - 1)) begin
                                depth <= '0;
                                row   <= row + HW'(1);
                            end else begin
                                depth <= depth + DPW'(1);
                            end
                        end
                    end
`ifdef CONV_FEEDER_TIMEOUT_EN
                    // err_o is raised on the last waiting cycle, the FSM leaves one cycle later
                    else if (tcnt == TCW'(TIMEOUT)) begin
                        state <= IDLE;
                        row   <= '0;
                        depth <= '0;
                    end else begin
                        tcnt  <= tcnt + TCW'(1);
                        err_o <= (tcnt == TCW'(TIMEOUT - 1));
                    end
`endif
                end
                FIN: begin
                    state <= IDLE;
                    row   <= '0;
                    depth <= '0;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_conv_line_feeder.sv
// Directed bench for conv_line_feeder: a default-size instance (reset, order, latency,
// spurious done) and a small D=1,H=3,W=2 instance (padding, optional watchdog).
module tb_conv_line_feeder;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int cmp_cnt = 0;
    int err_cnt = 0;

    // default-size instance
    logic              rst_a, valid_a, done_a;
    logic signed [7:0] pix_a;
    logic              ready_a, start_a, busy_a, fdone_a;
    logic [63:0]       img0_a, img1_a, img2_a;

    // small instance
    logic              rst_b, valid_b, done_b;
    logic signed [7:0] pix_b;
    logic              ready_b, start_b, busy_b, fdone_b;
    logic [31:0]       img0_b, img1_b, img2_b;
`ifdef CONV_FEEDER_TIMEOUT_EN
    logic              err_a, err_b;
`endif

    conv_line_feeder dut_a (
        .clk(clk), .rstn_i(rst_a), .pixel_i(pix_a), .pixel_valid_i(valid_a),
        .pixel_ready_o(ready_a), .conv_done_i(done_a),
        .image0(img0_a), .image1(img1_a), .image2(img2_a),
        .image_start(start_a), .busy_o(busy_a), .frame_done_o(fdone_a)
`ifdef CONV_FEEDER_TIMEOUT_EN
        , .err_o(err_a)
`endif
    );

    conv_line_feeder #(.D(1), .H(3), .W(2), .TIMEOUT(16)) dut_b (
        .clk(clk), .rstn_i(rst_b), .pixel_i(pix_b), .pixel_valid_i(valid_b),
        .pixel_ready_o(ready_b), .conv_done_i(done_b),
        .image0(img0_b), .image1(img1_b), .image2(img2_b),
        .image_start(start_b), .busy_o(busy_b), .frame_done_o(fdone_b)
`ifdef CONV_FEEDER_TIMEOUT_EN
        , .err_o(err_b)
`endif
    );

    int starts_a = 0;
    always @(negedge clk) if (!rst_a && start_a) starts_a++;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        cmp_cnt++;
        if (got !== exp) begin
            err_cnt++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // expected padded row for the default instance, pixel value = index mod 128
    function automatic logic [63:0] exp_a(int d, int r);
        logic [63:0] v = '0;
        if (r < 0 || r >= 6) return v;
        for (int c = 0; c < 6; c++) v[8*(c+1) +: 8] = 8'((d * 36 + r * 6 + c) % 128);
        return v;
    endfunction

    initial begin
        logic [31:0] eb0 [3];
        logic [31:0] eb1 [3];
        logic [31:0] eb2 [3];
        eb0[0] = 32'h0; eb1[0] = 32'h00020100; eb2[0] = 32'h00040300;
        eb0[1] = 32'h00020100; eb1[1] = 32'h00040300; eb2[1] = 32'h00060500;
        eb0[2] = 32'h00040300; eb1[2] = 32'h00060500; eb2[2] = 32'h0;

        rst_a = 1; valid_a = 0; done_a = 0; pix_a = '0;
        rst_b = 1; valid_b = 0; done_b = 0; pix_b = '0;
        repeat (3) tick();
        check("rst_ready", 64'(ready_a), 64'd0);
        check("rst_busy", 64'(busy_a), 64'd0);
        check("rst_start", 64'(start_a), 64'd0);
        check("rst_fdone", 64'(fdone_a), 64'd0);
        check("rst_img1", img1_a, 64'd0);
        check("rst_b_img0", 64'(img0_b), 64'd0);
        rst_a = 0; rst_b = 0;
        #1;
        check("rel_ready", 64'(ready_a), 64'd1);

        // partial frame, then reset mid-LOAD
        for (int i = 0; i < 50; i++) begin
            pix_a = 8'h55; valid_a = 1;
            tick();
        end
        valid_a = 0;
        check("load_busy", 64'(busy_a), 64'd1);
        rst_a = 1;
        repeat (3) tick();
        check("midrst_ready", 64'(ready_a), 64'd0);
        check("midrst_busy", 64'(busy_a), 64'd0);
        check("midrst_start", 64'(start_a), 64'd0);
        check("midrst_fdone", 64'(fdone_a), 64'd0);
        check("midrst_img0", img0_a, 64'd0);
        rst_a = 0;
        #1;
        check("midrel_ready", 64'(ready_a), 64'd1);
        check("midrel_busy", 64'(busy_a), 64'd0);

        // full frame with a spurious done during LOAD
        for (int i = 0; i < 144; i++) begin
            pix_a = 8'(i % 128); valid_a = 1;
            done_a = (i == 10);
            tick();
        end
        valid_a = 0; done_a = 0;
        check("lat_issue_start", 64'(start_a), 64'd0);
        check("lat_issue_ready", 64'(ready_a), 64'd0);
        tick();
        check("lat_load_start", 64'(start_a), 64'd1);

        for (int k = 0; k < 24; k++) begin
            check($sformatf("p%0d_img0", k), img0_a, exp_a(k % 4, k / 4 - 1));
            check($sformatf("p%0d_img1", k), img1_a, exp_a(k % 4, k / 4));
            check($sformatf("p%0d_img2", k), img2_a, exp_a(k % 4, k / 4 + 1));
            if (k == 5) check("p5_slot1", 64'(img1_a[15:8]), 64'd42);
            done_a = (k == 0);  // ignored: coincides with image_start
            tick();
            done_a = 0;
            check($sformatf("p%0d_hold", k), img1_a, exp_a(k % 4, k / 4));
            tick();
            done_a = 1;
            tick();
            done_a = 0;
            if (k < 23) begin
                check($sformatf("p%0d_issue_start", k), 64'(start_a), 64'd0);
                tick();
                check($sformatf("p%0d_done_start", k), 64'(start_a), 64'd1);
            end else begin
                check("fin_fdone", 64'(fdone_a), 64'd1);
                check("fin_ready", 64'(ready_a), 64'd0);
                tick();
                check("idle_fdone", 64'(fdone_a), 64'd0);
                check("idle_ready", 64'(ready_a), 64'd1);
                check("idle_busy", 64'(busy_a), 64'd0);
            end
        end
        check("start_count", 64'(starts_a), 64'd24);

        // small instance: padding
        for (int i = 0; i < 6; i++) begin
            pix_b = 8'(i + 1); valid_b = 1;
            tick();
        end
        valid_b = 0;
        check("b_issue_start", 64'(start_b), 64'd0);
        tick();
        for (int k = 0; k < 3; k++) begin
            check($sformatf("b%0d_start", k), 64'(start_b), 64'd1);
            check($sformatf("b%0d_img0", k), 64'(img0_b), 64'(eb0[k]));
            check($sformatf("b%0d_img1", k), 64'(img1_b), 64'(eb1[k]));
            check($sformatf("b%0d_img2", k), 64'(img2_b), 64'(eb2[k]));
            tick();
            done_b = 1;
            tick();
            done_b = 0;
            if (k < 2) tick();
        end
        check("b_fdone", 64'(fdone_b), 64'd1);
        tick();
        check("b_idle_ready", 64'(ready_b), 64'd1);

`ifdef CONV_FEEDER_TIMEOUT_EN
        for (int i = 0; i < 6; i++) begin
            pix_b = 8'(i + 1); valid_b = 1;
            tick();
        end
        valid_b = 0;
        tick();
        check("to_start", 64'(start_b), 64'd1);
        repeat (15) tick();
        check("to_err_early", 64'(err_b), 64'd0);
        tick();
        check("to_err", 64'(err_b), 64'd1);
        check("to_err_busy", 64'(busy_b), 64'd1);
        tick();
        check("to_err_clr", 64'(err_b), 64'd0);
        check("to_busy_fall", 64'(busy_b), 64'd0);
        check("to_ready", 64'(ready_b), 64'd1);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, err_cnt);
        $finish;
    end

endmodule

// File: doc/conv_line_feeder.md
CONV_LINE_FEEDER -- requirements
Module: conv_line_feeder

Interface
REQ-001 Parameter D, default 4, number of input channels (depth passes per output row).
REQ-002 Parameter H, default 6, image rows.
REQ-003 Parameter W, default 6, image columns; packed row width is W+2 pixels.
REQ-004 Parameter input_DATA_WIDTH, default 8, pixel width.
REQ-005 Parameter TIMEOUT, default 1024, watchdog limit in cycles (used only with the macro in REQ-030).
REQ-006 clk  input  1  the only clock; all state changes on its rising edge.
REQ-007 rstn_i  input  1  reset, synchronous and active-high (despite the name).
REQ-008 pixel_i  input  input_DATA_WIDTH  signed input pixel.
REQ-009 pixel_valid_i  input  1  pixel_i valid.
REQ-010 pixel_ready_o  output  1  feeder accepts a pixel this cycle.
REQ-011 conv_done_i  input  1  one-cycle pulse from the conv core when a pass completes.
REQ-012 image0  output  input_DATA_WIDTH*(W+2)  padded row r-1 of the current channel.
REQ-013 image1  output  input_DATA_WIDTH*(W+2)  padded row r.
REQ-014 image2  output  input_DATA_WIDTH*(W+2)  padded row r+1.
REQ-015 image_start  output  1  one-cycle pulse that starts a conv pass.
REQ-016 busy_o  output  1  high in every state except IDLE.
REQ-017 frame_done_o  output  1  one-cycle pulse after the last pass of a frame.

Function
REQ-018 A pixel SHALL transfer on a cycle where pixel_valid_i and pixel_ready_o are both high; pixel_ready_o is high only in IDLE and LOAD.
REQ-019 Pixels SHALL arrive channel-major, then row, then column: index = d*H*W + r*W + c; the frame holds D*H*W pixels in an internal register array.
REQ-020 States: IDLE (no pixel yet) -> LOAD on the first transfer; LOAD -> ISSUE on transfer D*H*W; ISSUE -> WAIT after one cycle; WAIT -> ISSUE on conv_done_i if passes remain, else -> FIN; FIN -> IDLE after one cycle.
REQ-021 Pass order: for r = 0..H-1, for d = 0..D-1, matching the conv core's depth counter 0..D-1 per row.
REQ-022 Packing: pixel slot j (0..W+1) occupies bits [input_DATA_WIDTH*(j+1)-1 : input_DATA_WIDTH*j]; slots 0 and W+1 are zero; slot c+1 holds column c.
REQ-023 Row r-1 for r=0 and row r+1 for r=H-1 SHALL be all zeros (vertical zero padding).
REQ-024 image0..2 SHALL be registered, loaded in ISSUE, and held stable from the image_start cycle until the next ISSUE.
REQ-025 image_start SHALL be high exactly the first cycle the new rows are valid: 2 cycles after the last pixel transfer, and 2 cycles after each non-final conv_done_i.
REQ-026 conv_done_i outside WAIT SHALL be ignored; a conv_done_i in the same cycle as image_start SHALL be ignored.
REQ-027 frame_done_o SHALL pulse in FIN, i.e. 1 cycle after the final (r=H-1, d=D-1) conv_done_i; pixel_ready_o returns high the following cycle.

Reset
REQ-028 On rstn_i high at a clock edge: state IDLE, row/depth/pixel counters 0, image0..2 zero, image_start, busy_o, frame_done_o, pixel_ready_o all 0; pixel array contents unspecified.
REQ-029 Reset mid-frame SHALL abandon the frame; pixel_ready_o is high the first cycle after rstn_i falls and a new frame starts at index 0.

Configuration
REQ-030 Macro CONV_FEEDER_TIMEOUT_EN: when defined, a counter runs in WAIT; if TIMEOUT cycles elapse without conv_done_i, output err_o (1 bit) pulses one cycle and the FSM returns to IDLE; when undefined, no err_o port, no counter, WAIT waits indefinitely.

Verification
REQ-031 Reset: assert rstn_i 3 cycles mid-LOAD -> all outputs 0; after release pixel_ready_o=1 and the next frame loads from index 0.
REQ-032 Padding: D=1,H=3,W=2, pixels 1..6 -> pass 0: image0=0, image1={0,2,1,0} (slot3..0), image2={0,4,3,0}; pass 2: image2=0.
REQ-033 Order: default params, pixel value = index mod 128 -> 24 image_start pulses; pass k carries channel k mod 4, row k/4; image1 slot1 of pass 5 = 1*36+1*6+0 = 42.
REQ-034 Latency: last pixel at cycle t -> image_start at t+2; conv_done_i at cycle u -> next image_start at u+2; final done at v -> frame_done_o at v+1.
REQ-035 Spurious done: pulse conv_done_i during LOAD and in the image_start cycle -> no pass advance, pass count still 24.
REQ-036 With CONV_FEEDER_TIMEOUT_EN, TIMEOUT=16, withhold conv_done_i -> err_o pulses 16 cycles after image_start, busy_o falls next cycle.
